// File: rtl/sig_acquire.sv
// sig_acquire: radio front-end capture into a FWFT FIFO with AXI-Stream framing,
// drop accounting and a periodic radio-reconfigure generator.
//
// Ports:
//   clock        signal clock, all logic on the rising edge
//   reset_n      asynchronous active-low reset, released synchronously
//   enable_i     capture enable, registered alongside the sample bits
//   clear_i      synchronous clear of FIFO, frame index, overflow and drop count
//   idata_i      raw I bits, one per antenna
//   qdata_i      raw Q bits, one per antenna
//   m_tvalid_o   stream valid
//   m_tready_i   stream ready
//   m_tlast_o    last sample of a FRAME-sample frame
//   m_tdata_o    {Q, I} sample
//   overflow_o   sticky flag: a sample was dropped
//   drops_o      saturating dropped-sample count
//   tick_o       one-cycle pulse at each timer terminal count
//   reconfig_o   radio reconfigure output (toggle / sampled I[0] / pulse)
module sig_acquire #(
    parameter int ANTENNAS = 24,
    parameter int DEPTH    = 16,
    parameter int FRAME    = 256,
    parameter int PERIOD   = 8_184_000,
    parameter int RMODE    = 0,
    parameter int DBITS    = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable_i,
    input  logic                    clear_i,
    input  logic [ANTENNAS-1:0]     idata_i,
    input  logic [ANTENNAS-1:0]     qdata_i,
    output logic                    m_tvalid_o,
    input  logic                    m_tready_i,
    output logic                    m_tlast_o,
    output logic [2*ANTENNAS-1:0]   m_tdata_o,
    output logic                    overflow_o,
    output logic [DBITS-1:0]        drops_o,
    output logic                    tick_o,
    output logic                    reconfig_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = FRAME > 1 ? $clog2(FRAME) : 1;
    localparam int TW = $clog2(PERIOD);
    localparam int W  = 2 * ANTENNAS + 1;

    logic [ANTENNAS-1:0] s_i_q, s_q_q;
    logic                s_v_q;
    logic [W-1:0]        mem_q [DEPTH];
    logic [AW:0]         wp_q, wp_d, rp_q, rp_d;
    logic [FW-1:0]       fc_q, fc_d;
    logic                ovf_q, ovf_d;
    logic [DBITS-1:0]    drops_q, drops_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic                tick_q, rc_q, rc_d;
    logic                empty, full, rd, wr, drop, last, tc;
    logic [W-1:0]        rdata;

    // Pointers carry an extra wrap bit so all DEPTH entries are usable.
    assign empty = wp_q == rp_q;
    assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign rd    = !empty && m_tready_i;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr    = s_v_q && (!full || rd) && !clear_i;
    assign drop  = s_v_q && full && !rd && !clear_i;
    assign last  = fc_q == FW'(FRAME - 1);
    assign tc    = tmr_q == TW'(PERIOD - 1);

    always_comb begin
        wp_d    = clear_i ? '0 : wp_q + {{AW{1'b0}}, wr};
        rp_d    = clear_i ? '0 : rp_q + {{AW{1'b0}}, rd};
        fc_d    = clear_i ? '0 : wr ? (last ? '0 : fc_q + 1'b1) : fc_q;
        ovf_d   = !clear_i && (ovf_q || drop);
        drops_d = clear_i ? '0 : (drop && drops_q != '1) ? drops_q + 1'b1 : drops_q;
        tmr_d   = tc ? '0 : tmr_q + 1'b1;
        rc_d    = tc ? (RMODE == 1 ? s_i_q[0] : !rc_q) : rc_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_i_q   <= '0;
            s_q_q   <= '0;
            s_v_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            fc_q    <= '0;
            ovf_q   <= 1'b0;
            drops_q <= '0;
            tmr_q   <= '0;
            tick_q  <= 1'b0;
            rc_q    <= 1'b0;
        end else begin
            s_i_q   <= idata_i;
            s_q_q   <= qdata_i;
            s_v_q   <= enable_i;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            fc_q    <= fc_d;
            ovf_q   <= ovf_d;
            drops_q <= drops_d;
            tmr_q   <= tmr_d;
            tick_q  <= tc;
            rc_q    <= rc_d;
        end
    end

    // Storage needs no reset: outputs are gated by the empty flag.
    always_ff @(posedge clock) begin
        if (wr)
            mem_q[wp_q[AW-1:0]] <= {last, s_q_q, s_i_q};
    end

    assign rdata      = mem_q[rp_q[AW-1:0]];
    assign m_tvalid_o = !empty;
    assign m_tlast_o  = !empty && rdata[W-1];
    assign m_tdata_o  = empty ? '0 : rdata[W-2:0];
    assign overflow_o = ovf_q;
    assign drops_o    = drops_q;
    assign tick_o     = tick_q;
    assign reconfig_o = RMODE == 2 ? tick_q : rc_q;
endmodule

// File: tb/tb_sig_acquire.sv
// tb_sig_acquire: directed + random checks of sig_acquire against a queue scoreboard.
module tb_sig_acquire;
    localparam int A = 24, D = 4, F = 4, P = 10;
    typedef logic [2*A:0] ent_t;

    logic clock = 0, reset_n = 1, enable_i = 0, clear_i = 0, m_tready_i = 0;
    logic [A-1:0] idata_i = 0, qdata_i = 0;
    logic v [4], l [4], o [4], t [4], r [4];
    logic [2*A-1:0] dat [4];
    logic [15:0] dr0, dr1, dr2;
    logic [2:0] dr3;

    sig_acquire #(.ANTENNAS(A), .DEPTH(D), .FRAME(F), .PERIOD(P), .RMODE(0), .DBITS(16)) u_a (
        .clock(clock), .reset_n(reset_n), .enable_i(enable_i), .clear_i(clear_i),
        .idata_i(idata_i), .qdata_i(qdata_i), .m_tvalid_o(v[0]), .m_tready_i(m_tready_i),
        .m_tlast_o(l[0]), .m_tdata_o(dat[0]), .overflow_o(o[0]), .drops_o(dr0),
        .tick_o(t[0]), .reconfig_o(r[0]));
    sig_acquire #(.ANTENNAS(A), .DEPTH(D), .FRAME(F), .PERIOD(P), .RMODE(1), .DBITS(16)) u_b (
        .clock(clock), .reset_n(reset_n), .enable_i(enable_i), .clear_i(clear_i),
        .idata_i(idata_i), .qdata_i(qdata_i), .m_tvalid_o(v[1]), .m_tready_i(m_tready_i),
        .m_tlast_o(l[1]), .m_tdata_o(dat[1]), .overflow_o(o[1]), .drops_o(dr1),
        .tick_o(t[1]), .reconfig_o(r[1]));
    sig_acquire #(.ANTENNAS(A), .DEPTH(D), .FRAME(F), .PERIOD(P), .RMODE(2), .DBITS(16)) u_c (
        .clock(clock), .reset_n(reset_n), .enable_i(enable_i), .clear_i(clear_i),
        .idata_i(idata_i), .qdata_i(qdata_i), .m_tvalid_o(v[2]), .m_tready_i(m_tready_i),
        .m_tlast_o(l[2]), .m_tdata_o(dat[2]), .overflow_o(o[2]), .drops_o(dr2),
        .tick_o(t[2]), .reconfig_o(r[2]));
    sig_acquire #(.ANTENNAS(A), .DEPTH(D), .FRAME(F), .PERIOD(P), .RMODE(0), .DBITS(3)) u_d (
        .clock(clock), .reset_n(reset_n), .enable_i(enable_i), .clear_i(clear_i),
        .idata_i(idata_i), .qdata_i(qdata_i), .m_tvalid_o(v[3]), .m_tready_i(m_tready_i),
        .m_tlast_o(l[3]), .m_tdata_o(dat[3]), .overflow_o(o[3]), .drops_o(dr3),
        .tick_o(t[3]), .reconfig_o(r[3]));

    always #5 clock = ~clock;

    ent_t q [$];
    int fr, dm, tm, hs, errs = 0, checks = 0;
    logic tk, rc0, rc1, ovf, sv, acc, rdm;
    logic [A-1:0] si, sq;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        q.delete();
        fr = 0; dm = 0; tm = 0; tk = 0; rc0 = 0; rc1 = 0; ovf = 0; sv = 0; si = '0; sq = '0;
    endtask

    // One clock: compare outputs with the scoreboard, advance the model, cross the edge.
    task automatic step();
        #1;
        chk("tvalid", 64'(v[0]), 64'(q.size() != 0));
        if (v[0] && m_tready_i) begin
            hs++;
            if (q.size() != 0) begin
                chk("tdata", 64'(dat[0]), 64'(q[0][2*A-1:0]));
                chk("tlast", 64'(l[0]), 64'(q[0][2*A]));
            end
        end
        chk("overflow", 64'(o[0]), 64'(ovf));
        chk("drops", 64'(dr0), 64'(dm > 65535 ? 65535 : dm));
        chk("drops_sat3", 64'(dr3), 64'(dm > 7 ? 7 : dm));
        chk("tick", 64'(t[0]), 64'(tk));
        chk("reconfig_toggle", 64'(r[0]), 64'(rc0));
        chk("reconfig_sample", 64'(r[1]), 64'(rc1));
        chk("reconfig_pulse", 64'(r[2]), 64'(tk));
        rdm = q.size() != 0 && m_tready_i;
        acc = sv && (q.size() < D || rdm);
        if (rdm) void'(q.pop_front());
        if (clear_i) begin
            q.delete(); fr = 0; ovf = 0; dm = 0;
        end else if (sv) begin
            if (acc) begin
                q.push_back(ent_t'({fr == F - 1, sq, si}));
                fr = (fr + 1) % F;
            end else begin
                ovf = 1; dm++;
            end
        end
        if (tm == P - 1) begin
            tm = 0; tk = 1; rc0 = ~rc0; rc1 = si[0];
        end else begin
            tm++; tk = 0;
        end
        sv = enable_i; si = idata_i; sq = qdata_i;
        @(posedge clock);
        @(negedge clock);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop before any edge.
    task automatic do_reset();
        #3 reset_n = 0;
        #1;
        chk("rst_tvalid", 64'(v[0]), 64'(0));
        chk("rst_tlast", 64'(l[0]), 64'(0));
        chk("rst_tdata", 64'(dat[0]), 64'(0));
        chk("rst_overflow", 64'(o[0]), 64'(0));
        chk("rst_drops", 64'(dr0), 64'(0));
        chk("rst_tick", 64'(t[0]), 64'(0));
        chk("rst_reconfig", 64'({r[0], r[1], r[2]}), 64'(0));
        model_init();
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1;
    endtask

    initial begin
        int d0;
        model_init();
        do_reset();
        // first word latency and framing with constant data
        enable_i = 1; idata_i = 24'h000001; qdata_i = 24'h800000; m_tready_i = 1;
        step(); step();
        chk("first_valid", 64'(v[0]), 64'(1));
        chk("first_word", 64'(dat[0]), 64'h800000000001);
        for (int i = 0; i < 8; i++) step();
        enable_i = 0;
        for (int i = 0; i < 4; i++) step();
        // overflow with back-pressure
        m_tready_i = 0; enable_i = 1;
        for (int i = 0; i < 10; i++) begin idata_i = $urandom; qdata_i = $urandom; step(); end
        enable_i = 0;
        for (int i = 0; i < 3; i++) step();
        chk("drops_6", 64'(dr0), 64'(6));
        chk("overflow_set", 64'(o[0]), 64'(1));
        m_tready_i = 1; hs = 0;
        for (int i = 0; i < 6; i++) step();
        chk("held_4", 64'(hs), 64'(4));
        // full FIFO with continuous read and write
        m_tready_i = 0; enable_i = 1;
        for (int i = 0; i < 6; i++) begin idata_i = $urandom; qdata_i = $urandom; step(); end
        m_tready_i = 1; d0 = int'(dr0); hs = 0;
        for (int i = 0; i < 100; i++) begin idata_i = $urandom; qdata_i = $urandom; step(); end
        chk("throughput_100", 64'(hs), 64'(100));
        chk("no_new_drops", 64'(dr0), 64'(d0));
        enable_i = 0;
        for (int i = 0; i < 6; i++) step();
        // clear with 3 words buffered and overflow set
        m_tready_i = 0; enable_i = 1;
        for (int i = 0; i < 3; i++) begin idata_i = $urandom; qdata_i = $urandom; step(); end
        enable_i = 0;
        step(); step();
        chk("pre_clear_overflow", 64'(o[0]), 64'(1));
        clear_i = 1;
        step();
        clear_i = 0;
        chk("clear_tvalid", 64'(v[0]), 64'(0));
        chk("clear_overflow", 64'(o[0]), 64'(0));
        chk("clear_drops", 64'(dr0), 64'(0));
        enable_i = 1; m_tready_i = 1;
        for (int i = 0; i < 8; i++) begin idata_i = $urandom; qdata_i = $urandom; step(); end
        enable_i = 0;
        for (int i = 0; i < 6; i++) step();
        // drop counter saturation on the narrow instance
        m_tready_i = 0; enable_i = 1;
        for (int i = 0; i < 15; i++) begin idata_i = $urandom; qdata_i = $urandom; step(); end
        enable_i = 0;
        step(); step();
        chk("sat_drops3", 64'(dr3), 64'(7));
        chk("drops_11", 64'(dr0), 64'(11));
        clear_i = 1; step(); clear_i = 0;
        // random traffic
        for (int i = 0; i < 200; i++) begin
            enable_i = 1'($urandom);
            m_tready_i = $urandom_range(0, 3) != 0;
            clear_i = $urandom_range(0, 30) == 0;
            idata_i = $urandom; qdata_i = $urandom;
            step();
        end
        clear_i = 0;
        // reset mid-frame with the FIFO partly filled
        m_tready_i = 1; enable_i = 1;
        for (int i = 0; i < 3; i++) begin idata_i = $urandom; qdata_i = $urandom; step(); end
        m_tready_i = 0;
        step(); step();
        enable_i = 0;
        step();
        do_reset();
        enable_i = 1; m_tready_i = 1; idata_i = 24'h000001;
        for (int k = 1; k <= 35; k++) begin
            qdata_i = $urandom;
            step();
            if (k == 10) begin
                chk("tick_edge10", 64'(t[0]), 64'(1));
                chk("reconfig_sample_edge10", 64'(r[1]), 64'(1));
            end
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/sig_acquire.md
Name: sig_acquire

Overview:
- Parametrised radio front-end capture block: registers ANTENNAS-wide I/Q sample buses and buffers them in a first-word-fall-through FIFO.
- Emits samples as AXI-Stream frames of FRAME samples with tlast.
- Counts and flags samples dropped on back-pressure.
- Generates the periodic radio-reconfigure signal in one of three selectable modes.
- Sits between the radio pins and the correlator or raw-capture path, in the signal clock domain.

Parameters:
- ANTENNAS, 24, number of I/Q input pairs; m_tdata_o width is 2*ANTENNAS.
- DEPTH, 16, FIFO entries; power of two, >=2.
- FRAME, 256, samples per output frame; >=1.
- PERIOD, 8_184_000, reconfig timer period in clock cycles; >=2.
- RMODE, 0, reconfig mode: 0 = toggle, 1 = sample I[0], 2 = one-cycle pulse.
- DBITS, 16, width of the drop counter.

Ports:
- clock  in  1  signal clock (16.368 MHz); all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable_i  in  1  capture enable, sampled with the data.
- clear_i  in  1  synchronous clear of the FIFO, frame counter, overflow flag and drop count.
- idata_i  in  ANTENNAS  raw I bits.
- qdata_i  in  ANTENNAS  raw Q bits.
- m_tvalid_o  out  1  stream valid.
- m_tready_i  in  1  stream ready.
- m_tlast_o  out  1  last sample of frame.
- m_tdata_o  out  2*ANTENNAS  {Q, I} sample.
- overflow_o  out  1  sticky: at least one sample dropped.
- drops_o  out  DBITS  saturating dropped-sample count.
- tick_o  out  1  one-cycle pulse at each timer terminal count.
- reconfig_o  out  1  radio reconfigure output.

Behaviour:
- Reset (async assert, sync release) clears all registers:
  - m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0.
  - overflow_o=0, drops_o=0, tick_o=0, reconfig_o=0.
  - FIFO empty; frame and timer counters 0.
  - Reset mid-frame discards buffered data; the next accepted sample is frame index 0.
- Stage 0: each edge registers idata_i, qdata_i and enable_i into s_i, s_q, s_v.
- Stage 1: if s_v=1, write {s_q, s_i} to the FIFO on the next edge.
  - Latency from pins to m_tvalid_o on an empty FIFO: 2 edges.
- Write is accepted when the FIFO is not full, or when it is full and a read (m_tvalid_o & m_tready_i) occurs in the same cycle.
- Write when full with no read: sample dropped, overflow_o<=1, drops_o increments and saturates at 2^DBITS-1; frame counter does not advance.
- Frame counter counts accepted writes 0..FRAME-1 and wraps to 0.
  - The tlast bit is stored with each entry; it is 1 when the written index is FRAME-1.
  - FRAME=1 gives tlast on every sample.
- Output handshake follows AXI-Stream rules:
  - m_tdata_o and m_tlast_o are valid whenever m_tvalid_o=1 and stay stable until the handshake.
  - m_tvalid_o never drops without a handshake, except on clear_i or reset.
- Simultaneous read and write on an empty FIFO: no bypass; the written word appears the next cycle.
- enable_i low: no writes; the frame counter holds its position (frames resume mid-frame when enable_i rises again).
- clear_i=1 takes priority over a write in the same cycle:
  - FIFO flushed, m_tvalid_o=0 next edge.
  - Frame counter=0, overflow_o=0, drops_o=0.
  - Stage-0 registers unaffected.
  - Timer unaffected.
- Timer: counts 0..PERIOD-1 every cycle regardless of enable_i.
  - At count PERIOD-1: wraps to 0, tick_o=1 for that one cycle (registered).
  - RMODE=0: reconfig_o toggles on each tick.
  - RMODE=1: reconfig_o loads s_i[0] on each tick.
  - RMODE=2: reconfig_o equals tick_o.
  - First tick occurs PERIOD edges after reset release.
- Full/empty tracking uses read/write pointers with one extra wrap bit; no off-by-one at DEPTH entries.

Test Plan:
- Reset then enable_i=1, idata_i=24'h000001, qdata_i=24'h800000, m_tready_i=1 -> m_tvalid_o rises 2 edges later with m_tdata_o=48'h800000_000001; with FRAME=4, m_tlast_o=1 on every 4th accepted sample.
- DEPTH=4, m_tready_i=0, enable_i=1 for 10 cycles -> exactly 4 entries held; overflow_o=1; drops_o=6; the frame index resumes correctly after m_tready_i=1 drains the FIFO.
- FIFO full with m_tready_i=1 and a continuous write -> no drops; throughput of 1 sample/cycle sustained for 100 cycles; drops_o stays 0.
- clear_i pulse while the FIFO holds 3 words and overflow_o=1 -> next edge m_tvalid_o=0, overflow_o=0, drops_o=0; the next accepted sample is frame index 0 (tlast after FRAME samples).
- PERIOD=10: RMODE=0 -> reconfig_o toggles at edges 10, 20, 30 with tick_o pulses; RMODE=1 with idata_i[0]=1 -> reconfig_o=1 at edge 10; RMODE=2 -> reconfig_o is high for exactly 1 cycle.
- Assert reset_n low asynchronously mid-frame with the FIFO half full -> all outputs 0 immediately; after release, stream restarts at frame index 0 and the timer restarts from 0.
